// File: rtl/mfm_sector_sched.sv
// rtl/mfm_sector_sched.sv - MFM drive spindle/sector timing generator with sector-request scheduler
// Outputs are registered from next-state values so they reflect pos in the same cycle.
module mfm_sector_sched #(
  parameter int REV_CYCLES    = 833_335,
  parameter int INDEX_CYCLES  = 10_000,
  parameter int GAP0_CYCLES   = 1_000,
  parameter int SECTOR_CYCLES = 48_960,
  parameter int SECTORS       = 17,
  parameter int SPINUP_REVS   = 3
) (
  input  logic       clk50,
  input  logic       reset_l,
  input  logic       enable,
  output logic       index_l,
  output logic       ready_l,
  output logic [4:0] sector,
  output logic       sector_active,
  output logic       sector_start,
  input  logic       req_valid,
  input  logic [4:0] req_sector,
  output logic       req_ready,
  output logic       ack,
  output logic       err
);

  localparam logic [1:0] ST_STOP   = 2'd0;
  localparam logic [1:0] ST_SPINUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [19:0] POS_LAST  = 20'(REV_CYCLES - 1);
  localparam logic [19:0] INDEX_END = 20'(INDEX_CYCLES);
  localparam logic [19:0] GAP0_POS  = 20'(GAP0_CYCLES);
  localparam logic [19:0] CNT_LAST  = 20'(SECTOR_CYCLES - 1);
  localparam logic [4:0]  SEC_LAST  = 5'(SECTORS - 1);
  localparam logic [5:0]  SEC_COUNT = 6'(SECTORS);
  localparam logic [7:0]  REV_LAST  = 8'(SPINUP_REVS - 1);

  logic [1:0]  state_q, state_d;
  logic [19:0] pos_q, pos_d;
  logic [7:0]  rev_q, rev_d;
  logic [19:0] cnt_q, cnt_d;
  logic [4:0]  sec_q, sec_d;
  logic        active_q, active_d;
  logic        start_q, start_d;
  logic        index_l_q, index_l_d;
  logic        ready_l_q, ready_l_d;
  logic        req_ready_q, req_ready_d;
  logic        pending_q, pending_d;
  logic [4:0]  tgt_q, tgt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic running_d;
  logic accept;
  logic sec_ok;

  always_comb begin
    state_d = state_q;
    rev_d   = rev_q;
    case (state_q)
      ST_STOP: begin
        rev_d = 8'd0;
        if (enable) state_d = ST_SPINUP;
      end
      ST_SPINUP: begin
        if (!enable) begin
          state_d = ST_STOP;
        end else if (pos_q == POS_LAST) begin
          if (rev_q == REV_LAST) state_d = ST_RUN;
          else                   rev_d = rev_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (!enable) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase

    running_d = (state_d != ST_STOP);

    if (!running_d || state_q == ST_STOP) pos_d = 20'd0;
    else if (pos_q == POS_LAST)           pos_d = 20'd0;
    else                                  pos_d = pos_q + 20'd1;

    // Windows are contiguous: each sector starts when the previous one's in-sector count expires.
    active_d = active_q;
    sec_d    = sec_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    if (!running_d) begin
      active_d = 1'b0;
      sec_d    = 5'd0;
      cnt_d    = 20'd0;
    end else if (pos_d == GAP0_POS) begin
      active_d = 1'b1;
      sec_d    = 5'd0;
      cnt_d    = 20'd0;
      start_d  = 1'b1;
    end else if (pos_d == 20'd0) begin
      active_d = 1'b0;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = 20'd0;
        if (sec_q == SEC_LAST) begin
          active_d = 1'b0;
        end else begin
          sec_d   = sec_q + 5'd1;
          start_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end

    accept    = req_valid && req_ready_q;
    sec_ok    = ({1'b0, req_sector} < SEC_COUNT);
    pending_d = pending_q;
    tgt_d     = tgt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      if (sec_ok) begin
        pending_d = 1'b1;
        tgt_d     = req_sector;
      end else begin
        err_d = 1'b1;
      end
    end
    // A start already visible during the accept cycle was computed earlier, so it is naturally missed.
    if (start_d && pending_d && sec_d == tgt_d) begin
      ack_d     = 1'b1;
      pending_d = 1'b0;
    end
    if (state_d != ST_RUN) begin
      pending_d = 1'b0;
      ack_d     = 1'b0;
      err_d     = 1'b0;
    end

    req_ready_d = (state_d == ST_RUN) && !pending_d && !ack_d;
    index_l_d   = !(running_d && pos_d < INDEX_END);
    ready_l_d   = (state_d != ST_RUN);
  end

  always_ff @(posedge clk50) begin
    if (!reset_l) begin
      state_q     <= ST_STOP;
      pos_q       <= 20'd0;
      rev_q       <= 8'd0;
      cnt_q       <= 20'd0;
      sec_q       <= 5'd0;
      active_q    <= 1'b0;
      start_q     <= 1'b0;
      index_l_q   <= 1'b1;
      ready_l_q   <= 1'b1;
      req_ready_q <= 1'b0;
      pending_q   <= 1'b0;
      tgt_q       <= 5'd0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      rev_q       <= rev_d;
      cnt_q       <= cnt_d;
      sec_q       <= sec_d;
      active_q    <= active_d;
      start_q     <= start_d;
      index_l_q   <= index_l_d;
      ready_l_q   <= ready_l_d;
      req_ready_q <= req_ready_d;
      pending_q   <= pending_d;
      tgt_q       <= tgt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign index_l       = index_l_q;
  assign ready_l       = ready_l_q;
  assign sector        = sec_q;
  assign sector_active = active_q;
  assign sector_start  = start_q;
  assign req_ready     = req_ready_q;
  assign ack           = ack_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mfm_sector_sched.sv
// tb/tb_mfm_sector_sched.sv - directed self-checking bench for mfm_sector_sched with shortened timing
module tb_mfm_sector_sched;

  localparam int REV  = 200;
  localparam int IDX  = 10;
  localparam int GAP  = 5;
  localparam int SEC  = 10;
  localparam int NS   = 17;
  localparam int SPIN = 3;

  logic       clk50 = 1'b0;
  logic       reset_l;
  logic       enable;
  logic       index_l;
  logic       ready_l;
  logic [4:0] sector;
  logic       sector_active;
  logic       sector_start;
  logic       req_valid;
  logic [4:0] req_sector;
  logic       req_ready;
  logic       ack;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mfm_sector_sched #(
    .REV_CYCLES(REV), .INDEX_CYCLES(IDX), .GAP0_CYCLES(GAP),
    .SECTOR_CYCLES(SEC), .SECTORS(NS), .SPINUP_REVS(SPIN)
  ) dut (
    .clk50(clk50), .reset_l(reset_l), .enable(enable),
    .index_l(index_l), .ready_l(ready_l), .sector(sector),
    .sector_active(sector_active), .sector_start(sector_start),
    .req_valid(req_valid), .req_sector(req_sector), .req_ready(req_ready),
    .ack(ack), .err(err)
  );

  always #5 clk50 = ~clk50;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk50);
    @(negedge clk50);
    cyc++;
  endtask

  function automatic int pos();
    return cyc % REV;
  endfunction

  task automatic wait_pos(input int p);
    int n = 0;
    while (pos() != p && n < 2 * REV) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0; enable = 1'b1; req_valid = 1'b0; req_sector = 5'd0;
    repeat (3) step();
    n_checks++;
    if ({index_l, ready_l, sector, sector_active, sector_start, req_ready, ack, err} !== 12'b11_00000_00000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 110000000000",
               {index_l, ready_l, sector, sector_active, sector_start, req_ready, ack, err});
    end
    reset_l = 1'b1; enable = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({index_l, ready_l, sector, sector_active, sector_start, req_ready, ack, err} !== 12'b11_00000_00000) begin
      n_fail++;
      $display("FAIL stop_outputs: got %b want 110000000000",
               {index_l, ready_l, sector, sector_active, sector_start, req_ready, ack, err});
    end
  endtask

  task automatic test_spinup();
    logic [11:0] exp_v;
    logic [11:0] obs_v;
    int p;
    int e_sec;
    logic e_act;
    enable = 1'b1;
    cyc = -1;
    for (int t = 0; t < SPIN * REV + 2; t++) begin
      step();
      p     = t % REV;
      e_act = (p >= GAP) && (p < GAP + NS * SEC);
      if (e_act)                  e_sec = (p - GAP) / SEC;
      else if (p >= GAP + NS * SEC) e_sec = NS - 1;
      else                        e_sec = (t < REV) ? 0 : NS - 1;
      exp_v = {(p >= IDX), (t < SPIN * REV), (t >= SPIN * REV), e_act,
               (e_act && ((p - GAP) % SEC == 0)), 5'(e_sec), 1'b0, 1'b0};
      obs_v = {index_l, ready_l, req_ready, sector_active, sector_start, sector, ack, err};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL spinup_t%0d: got %b want %b (idx,rdy,rr,act,st,sec,ack,err)", t, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_request();
    int n = 0;
    wait_pos(20);
    req_valid = 1'b1; req_sector = 5'd5;
    step();
    req_valid = 1'b0;
    n_checks++;
    if ({req_ready, err, ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL req_accept: got rr,err,ack=%b want 000", {req_ready, err, ack});
    end
    while (ack !== 1'b1 && n < REV) begin step(); n++; end
    n_checks++;
    if (ack !== 1'b1 || pos() != GAP + 5 * SEC || sector !== 5'd5 || sector_start !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ack: got ack=%b pos=%0d sector=%0d start=%b want ack=1 pos=%0d sector=5 start=1",
               ack, pos(), sector, sector_start, GAP + 5 * SEC);
    end
    step();
    n_checks++;
    if ({req_ready, ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL req_ready_after_ack: got rr,ack=%b want 10", {req_ready, ack});
    end
  endtask

  task automatic test_back_to_back();
    wait_pos(GAP + 3 * SEC - 1);
    req_valid = 1'b1; req_sector = 5'd3;
    step();
    req_valid = 1'b0;
    n_checks++;
    if ({ack, sector_start, sector} !== 7'b11_00011) begin
      n_fail++;
      $display("FAIL ack_next_cycle: got ack,start,sector=%b want 1100011", {ack, sector_start, sector});
    end
    step();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_quick_ack: got %b want 1", req_ready);
    end
  endtask

  task automatic test_missed();
    int acc;
    int n = 0;
    wait_pos(GAP + 3 * SEC);
    n_checks++;
    if ({sector_start, sector, req_ready} !== 7'b1_00011_1) begin
      n_fail++;
      $display("FAIL missed_setup: got start,sector,rr=%b want 1000111", {sector_start, sector, req_ready});
    end
    req_valid = 1'b1; req_sector = 5'd3;
    acc = cyc;
    step();
    req_valid = 1'b0;
    while (ack !== 1'b1 && n < 2 * REV) begin step(); n++; end
    n_checks++;
    if (ack !== 1'b1 || cyc - acc != REV) begin
      n_fail++;
      $display("FAIL missed_ack_delay: got ack=%b delay=%0d want ack=1 delay=%0d", ack, cyc - acc, REV);
    end
    step();
  endtask

  task automatic test_err();
    int acks = 0;
    int drops = 0;
    req_valid = 1'b1; req_sector = 5'd17;
    step();
    req_valid = 1'b0;
    n_checks++;
    if ({err, ack, req_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL err_17: got err,ack,rr=%b want 101", {err, ack, req_ready});
    end
    step();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_one_cycle: got %b want 0", err);
    end
    req_valid = 1'b1; req_sector = 5'd31;
    step();
    req_valid = 1'b0;
    n_checks++;
    if ({err, req_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL err_31: got err,rr=%b want 11", {err, req_ready});
    end
    for (int i = 0; i < REV + 5; i++) begin
      step();
      if (ack === 1'b1) acks++;
      if (req_ready !== 1'b1) drops++;
    end
    n_checks++;
    if (acks != 0 || drops != 0) begin
      n_fail++;
      $display("FAIL err_no_pending: got acks=%0d ready_drops=%0d want 0 0", acks, drops);
    end
  endtask

  task automatic test_disable();
    int acks = 0;
    int n = 0;
    wait_pos(60);
    req_valid = 1'b1; req_sector = 5'd10;
    step();
    req_valid = 1'b0;
    step();
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_pending: got rr=%b want 0", req_ready);
    end
    enable = 1'b0;
    step();
    n_checks++;
    if ({index_l, ready_l, sector, sector_active, sector_start, req_ready, ack, err} !== 12'b11_00000_00000) begin
      n_fail++;
      $display("FAIL disable_outputs: got %b want 110000000000",
               {index_l, ready_l, sector, sector_active, sector_start, req_ready, ack, err});
    end
    for (int i = 0; i < REV; i++) begin
      step();
      if (ack === 1'b1) acks++;
    end
    enable = 1'b1;
    cyc = -1;
    step();
    n_checks++;
    if ({index_l, ready_l, sector} !== 7'b01_00000) begin
      n_fail++;
      $display("FAIL reenable_e1: got idx,rdy,sector=%b want 0100000", {index_l, ready_l, sector});
    end
    while (ready_l !== 1'b0 && n < 4 * REV) begin
      step();
      n++;
      if (ack === 1'b1) acks++;
    end
    n_checks++;
    if (cyc != SPIN * REV || req_ready !== 1'b1 || acks != 0) begin
      n_fail++;
      $display("FAIL reenable_spinup: got ready at t=%0d rr=%b acks=%0d want t=%0d rr=1 acks=0",
               cyc, req_ready, acks, SPIN * REV);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int acks = 0;
    wait_pos(60);
    req_valid = 1'b1; req_sector = 5'd12;
    step();
    req_valid = 1'b0;
    reset_l = 1'b0;
    step();
    n_checks++;
    if ({index_l, ready_l, sector_active, req_ready, ack} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b want 11000", {index_l, ready_l, sector_active, req_ready, ack});
    end
    reset_l = 1'b1;
    cyc = -1;
    step();
    while (ready_l !== 1'b0 && n < 4 * REV) begin
      step();
      n++;
      if (ack === 1'b1) acks++;
    end
    n_checks++;
    if (cyc != SPIN * REV || acks != 0) begin
      n_fail++;
      $display("FAIL reset_mid_spinup: got ready at t=%0d acks=%0d want t=%0d acks=0", cyc, acks, SPIN * REV);
    end
  endtask

  initial begin
    reset_l = 1'b0; enable = 1'b0; req_valid = 1'b0; req_sector = 5'd0;
    test_reset();
    test_spinup();
    test_request();
    test_back_to_back();
    test_missed();
    test_err();
    test_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mfm_sector_sched.md
MFM_SECTOR_SCHED -- requirements
Module: mfm_sector_sched

Interface
REQ-001 SHALL have parameter REV_CYCLES, default 833_335, clocks per revolution (16.667 ms at 50 MHz).
REQ-002 SHALL have parameter INDEX_CYCLES, default 10_000, index pulse width (200 us).
REQ-003 SHALL have parameter GAP0_CYCLES, default 1_000, offset from index leading edge to sector 0 start.
REQ-004 SHALL have parameter SECTOR_CYCLES, default 48_960, sector window length.
REQ-005 SHALL have parameter SECTORS, default 17, sectors per track.
REQ-006 SHALL have parameter SPINUP_REVS, default 3, revolutions before ready.
REQ-007 SHALL have port clk50, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port reset_l, input, 1, synchronous, active-low reset.
REQ-009 SHALL have port enable, input, 1, spindle on.
REQ-010 SHALL have port index_l, output, 1, active-low index pulse.
REQ-011 SHALL have port ready_l, output, 1, active-low drive ready.
REQ-012 SHALL have port sector, output, 5, current sector number.
REQ-013 SHALL have port sector_active, output, 1, high inside any sector window.
REQ-014 SHALL have port sector_start, output, 1, one-cycle strobe on first cycle of each sector window.
REQ-015 SHALL have ports req_valid (input, 1), req_sector (input, 5), req_ready (output, 1), forming the sector-request handshake.
REQ-016 SHALL have ports ack (output, 1) and err (output, 1): one-cycle request completion and rejection strobes.

Function
REQ-017 SHALL hold a 20-bit position counter pos, 0..REV_CYCLES-1, incrementing each running cycle and wrapping to 0 after REV_CYCLES-1.
REQ-018 SHALL implement states STOP, SPINUP, RUN: STOP->SPINUP on enable=1; SPINUP->RUN on pos wrap after SPINUP_REVS full revolutions; any state->STOP on enable=0 within one cycle.
REQ-019 SHALL, on the first running edge E1, load pos=0; all outputs are registered and reflect pos in the same cycle.
REQ-020 SHALL drive index_l=0 while running and pos<INDEX_CYCLES, else 1.
REQ-021 SHALL define sector k window as pos in [GAP0_CYCLES+k*SECTOR_CYCLES, GAP0_CYCLES+(k+1)*SECTOR_CYCLES), k=0..SECTORS-1, using a sector counter and an in-sector counter (no multiplier).
REQ-022 SHALL drive sector_active=1 inside a window; sector holds k during window and last value in trailing gap; sector_start=1 on first cycle of each window; timing runs in SPINUP and RUN.
REQ-023 SHALL drive ready_l=0 only in RUN.
REQ-024 SHALL drive req_ready=1 only in RUN with no pending request; accepts on req_valid&req_ready.
REQ-025 SHALL reject accepted req_sector>=SECTORS with err=1 on the next cycle; no request becomes pending.
REQ-026 SHALL make a valid accepted request pending from the following cycle; ack=1 coincident with the next sector_start whose sector equals the target, then clear pending (req_ready=1 next cycle).
REQ-027 SHALL treat a target sector_start coinciding with the accept cycle as missed; ack follows one revolution later.
REQ-028 SHALL, on enable=0, set pos=0, clear pending without ack and without err, and force STOP outputs.
REQ-029 SHALL never leave a pending request for more than REV_CYCLES cycles while in RUN.

Reset
REQ-030 SHALL, while reset_l=0 at a clock edge, enter STOP with pos=0, no pending request, and revolution count 0.
REQ-031 SHALL, in STOP and during reset, drive index_l=1, ready_l=1, sector=0, sector_active=0, sector_start=0, req_ready=0, ack=0, err=0.
REQ-032 SHALL, on reset mid-revolution or mid-request, drop the request silently and restart spin-up from revolution 0.

Verification
REQ-033 SHALL be checked with: reset release, enable=1 -> index_l low cycles E1..E1+9999, high at E1+10000; sector_start at E1+1000 with sector=0; sector 16 ends at E1+833_319; index_l low again at E1+833_335.
REQ-034 SHALL be checked with: continuous enable -> ready_l=1 through E1+2_500_004, ready_l=0 at E1+2_500_005; req_ready rises the same cycle.
REQ-035 SHALL be checked with: in RUN, request sector 5 at pos=100 -> ack exactly at pos=1000+5*48_960=245_800, sector=5, req_ready=1 next cycle.
REQ-036 SHALL be checked with: request sector 3 accepted at the exact sector 3 start cycle -> no ack that revolution; ack one REV_CYCLES later.
REQ-037 SHALL be checked with: request sector 17 -> err pulse one cycle after accept, no ack, req_ready stays 1.
REQ-038 SHALL be checked with: pending request, enable=0 -> next cycle index_l=1, ready_l=1, no ack; re-enable -> full 3-revolution spin-up before ready_l=0.
